axi4_lite_slave_regs: RTL and testbench

AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

---
 rtl/axi4_lite_slave_regs.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with independent read/write FSMs.
// Optional byte-lane write masking is enabled by defining AXI_SLAVE_WSTRB_EN.
`timescale 1ns/1ps

module axi4_lite_slave_regs #(
  parameter int NUM_REGS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [31:0]             S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]  Reg_Out,
  output logic                    Wr_Pulse,
  output logic [3:0]              Wr_Index
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // Handshake rule on every channel: a beat transfers on a rising edge where
  // VALID and READY are both 1; a raised VALID and its payload hold until then.
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  wr_state_t   r_wr_state;
  rd_state_t   r_rd_state;
  logic [31:0] r_regs [NUM_REGS];
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_wr_pulse;
  logic [3:0]  r_wr_index;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_wr_commit;
  logic [31:0]      w_wr_addr;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_wr_strb;
  logic [31:0]      w_wr_word;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_in_range;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_in_range;
  logic             w_unused;

  assign S_AXI_AWREADY = (r_wr_state == W_IDLE) && !r_aw_done;
  assign S_AXI_WREADY  = (r_wr_state == W_IDLE) && !r_w_done;
  assign S_AXI_ARREADY = (r_rd_state == R_IDLE);
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign Wr_Pulse      = r_wr_pulse;
  assign Wr_Index      = r_wr_index;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A beat arriving this cycle is used directly so the commit happens on the
  // same edge as the last handshake, giving BVALID one cycle later.
  assign w_wr_addr     = r_aw_done ? r_awaddr : S_AXI_AWADDR;
  assign w_wr_data     = r_w_done ? r_wdata : S_AXI_WDATA;
  assign w_wr_strb     = r_w_done ? r_wstrb : S_AXI_WSTRB;
  assign w_wr_commit   = (r_wr_state == W_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_wr_idx      = w_wr_addr[IDX_W+1:2];
  assign w_wr_in_range = (w_wr_addr[31:IDX_W+2] == '0);
  assign w_rd_idx      = S_AXI_ARADDR[IDX_W+1:2];
  assign w_rd_in_range = (S_AXI_ARADDR[31:IDX_W+2] == '0);

`ifdef AXI_SLAVE_WSTRB_EN
  always_comb begin
    w_wr_word = r_regs[w_wr_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_wr_strb[b]) w_wr_word[8*b +: 8] = w_wr_data[8*b +: 8];
    end
  end
  assign w_unused = ^{w_wr_addr[1:0], S_AXI_ARADDR[1:0]};
`else
  assign w_wr_word = w_wr_data;
  assign w_unused  = ^{w_wr_addr[1:0], S_AXI_ARADDR[1:0], w_wr_strb};
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign Reg_Out[32*g +: 32] = r_regs[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      case (r_wr_state)
        W_IDLE: begin
          if (w_wr_commit) begin
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_wr_state <= W_RESP;
            if (w_wr_in_range) begin
              r_regs[w_wr_idx] <= w_wr_word;
              r_wr_pulse       <= 1'b1;
              r_wr_index       <= 4'(w_wr_idx);
              r_bresp          <= 2'b00;
            end else begin
              r_bresp <= 2'b10;
            end
          end else begin
            if (w_aw_hs) begin
              r_aw_done <= 1'b1;
              r_awaddr  <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
              r_w_done <= 1'b1;
              r_wdata  <= S_AXI_WDATA;
              r_wstrb  <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // r_regs is sampled before the write block's non-blocking update lands,
  // so a same-cycle write to the read register returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_rvalid   <= 1'b0;
      r_rresp    <= 2'b00;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rvalid   <= 1'b1;
            r_rd_state <= R_DATA;
            if (w_rd_in_range) begin
              r_rdata <= r_regs[w_rd_idx];
              r_rresp <= 2'b00;
            end else begin
              r_rdata <= '0;
              r_rresp <= 2'b10;
            end
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed testbench for axi4_lite_slave_regs (NUM_REGS=8); expectations follow AXI_SLAVE_WSTRB_EN.
`timescale 1ns/1ps

module tb_axi4_lite_slave_regs;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   S_AXI_AWADDR;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [31:0]   S_AXI_ARADDR;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [N*32-1:0] Reg_Out;
  logic          Wr_Pulse;
  logic [3:0]    Wr_Index;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_regs [N];

  axi4_lite_slave_regs #(.NUM_REGS(N)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .Reg_Out(Reg_Out), .Wr_Pulse(Wr_Pulse), .Wr_Index(Wr_Index)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*32-1:0] pack_model();
    logic [N*32-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = exp_regs[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_regs[i] = 32'h0;
  endtask

  // Driver only: full write with BREADY=1, leaves the bus idle.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b exp 0", S_AXI_BVALID); end
    checks++; if (S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b exp 0", S_AXI_RVALID); end
    checks++; if (S_AXI_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", S_AXI_RDATA); end
    checks++; if (Reg_Out !== '0) begin errors++; $display("FAIL rst_regs: got %h exp 0", Reg_Out); end
    checks++; if (Wr_Pulse !== 1'b0 || Wr_Index !== 4'd0) begin errors++; $display("FAIL rst_wr: got pulse %b idx %0d exp 0 0", Wr_Pulse, Wr_Index); end
    tick(); tick();
    rst = 1'b0;
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin errors++; $display("FAIL rst_ready: got %b exp 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    tick();
  endtask

  task automatic test_same_cycle_write();
    S_AXI_AWADDR = 32'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin errors++; $display("FAIL same_ready: got %b exp 11", {S_AXI_AWREADY, S_AXI_WREADY}); end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    exp_regs[1] = 32'hDEADBEEF;
    checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL same_b: got valid %b resp %b exp 1 00", S_AXI_BVALID, S_AXI_BRESP); end
    checks++; if (Reg_Out !== pack_model()) begin errors++; $display("FAIL same_regs: got %h exp %h", Reg_Out, pack_model()); end
    checks++; if (Wr_Pulse !== 1'b1 || Wr_Index !== 4'd1) begin errors++; $display("FAIL same_pulse: got pulse %b idx %0d exp 1 1", Wr_Pulse, Wr_Index); end
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin errors++; $display("FAIL same_resp_ready: got %b exp 00", {S_AXI_AWREADY, S_AXI_WREADY}); end
    tick();
    checks++; if (S_AXI_BVALID !== 1'b0 || Wr_Pulse !== 1'b0) begin errors++; $display("FAIL same_done: got bvalid %b pulse %b exp 0 0", S_AXI_BVALID, Wr_Pulse); end
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin errors++; $display("FAIL same_idle_ready: got %b exp 11", {S_AXI_AWREADY, S_AXI_WREADY}); end
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_w_before_aw();
    S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    checks++; if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL wfirst_ready: got wr %b awr %b exp 0 1", S_AXI_WREADY, S_AXI_AWREADY); end
    checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL wfirst_early_b: got %b exp 0", S_AXI_BVALID); end
    tick(); tick();
    checks++; if (S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL wfirst_wait: got wr %b bv %b exp 0 0", S_AXI_WREADY, S_AXI_BVALID); end
    S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    exp_regs[2] = 32'h12345678;
    checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL wfirst_b: got valid %b resp %b exp 1 00", S_AXI_BVALID, S_AXI_BRESP); end
    checks++; if (Reg_Out !== pack_model()) begin errors++; $display("FAIL wfirst_regs: got %h exp %h", Reg_Out, pack_model()); end
    checks++; if (Wr_Pulse !== 1'b1 || Wr_Index !== 4'd2) begin errors++; $display("FAIL wfirst_pulse: got pulse %b idx %0d exp 1 2", Wr_Pulse, Wr_Index); end
    tick();
    checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || Wr_Pulse !== 1'b0) begin errors++; $display("FAIL wfirst_hold: got bv %b resp %b pulse %b exp 1 00 0", S_AXI_BVALID, S_AXI_BRESP, Wr_Pulse); end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    checks++; if (S_AXI_BVALID !== 1'b0 || S_AXI_WREADY !== 1'b1) begin errors++; $display("FAIL wfirst_done: got bv %b wr %b exp 0 1", S_AXI_BVALID, S_AXI_WREADY); end
  endtask

  task automatic test_out_of_range();
    S_AXI_AWADDR = 32'h20; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b10) begin errors++; $display("FAIL oor_b: got valid %b resp %b exp 1 10", S_AXI_BVALID, S_AXI_BRESP); end
    checks++; if (Wr_Pulse !== 1'b0) begin errors++; $display("FAIL oor_pulse: got %b exp 0", Wr_Pulse); end
    checks++; if (Reg_Out !== pack_model()) begin errors++; $display("FAIL oor_regs: got %h exp %h", Reg_Out, pack_model()); end
    tick();
    S_AXI_BREADY = 1'b0;
    checks++; if (S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL oor_bdone: got %b exp 0", S_AXI_BVALID); end
    S_AXI_ARADDR = 32'h20; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    tick();
    S_AXI_ARVALID = 1'b0;
    checks++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== 2'b10) begin errors++; $display("FAIL oor_read: got v %b d %h r %b exp 1 0 10", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP); end
    S_AXI_RREADY = 1'b1;
    tick();
    checks++; if (S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL oor_rdone: got %b exp 0", S_AXI_RVALID); end
    S_AXI_ARADDR = 32'h80000004; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    checks++; if (S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== 2'b10) begin errors++; $display("FAIL oor_high_read: got d %h r %b exp 0 10", S_AXI_RDATA, S_AXI_RRESP); end
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_read_backpressure();
    S_AXI_ARADDR = 32'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    tick();
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hDEADBEEF || S_AXI_RRESP !== 2'b00 || S_AXI_ARREADY !== 1'b0) begin
        errors++;
        $display("FAIL rd_hold[%0d]: got v %b d %h r %b arr %b exp 1 deadbeef 00 0", i, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY);
      end
      if (i < 4) tick();
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    checks++; if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL rd_release: got v %b arr %b exp 0 1", S_AXI_RVALID, S_AXI_ARREADY); end
  endtask

  task automatic test_concurrent();
    do_write(32'h0C, 32'hA5A5A5A5, 4'hF);
    exp_regs[3] = 32'hA5A5A5A5;
    S_AXI_ARADDR = 32'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checks++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hA5A5A5A5) begin errors++; $display("FAIL conc_old: got v %b d %h exp 1 a5a5a5a5", S_AXI_RVALID, S_AXI_RDATA); end
    exp_regs[3] = 32'h5A5A5A5A;
    checks++; if (S_AXI_BVALID !== 1'b1 || Reg_Out !== pack_model()) begin errors++; $display("FAIL conc_write: got bv %b regs %h exp 1 %h", S_AXI_BVALID, Reg_Out, pack_model()); end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_wstrb();
    do_write(32'h00, 32'hFFFFFFFF, 4'hF);
    do_write(32'h00, 32'h00000000, 4'b0101);
`ifdef AXI_SLAVE_WSTRB_EN
    exp_regs[0] = 32'hFF00FF00;
`else
    exp_regs[0] = 32'h00000000;
`endif
    checks++; if (Reg_Out[31:0] !== exp_regs[0]) begin errors++; $display("FAIL wstrb_reg0: got %h exp %h", Reg_Out[31:0], exp_regs[0]); end
    checks++; if (Reg_Out !== pack_model()) begin errors++; $display("FAIL wstrb_regs: got %h exp %h", Reg_Out, pack_model()); end
  endtask

  task automatic test_back_to_back();
    S_AXI_AWADDR = 32'h1C; S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    checks++; if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL b2b_awfirst: got awr %b wr %b bv %b exp 0 1 0", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID); end
    S_AXI_WDATA = 32'h77770001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    exp_regs[7] = 32'h77770001;
    checks++; if (S_AXI_BVALID !== 1'b1 || Wr_Index !== 4'd7 || Reg_Out !== pack_model()) begin errors++; $display("FAIL b2b_first: got bv %b idx %0d regs %h exp 1 7 %h", S_AXI_BVALID, Wr_Index, Reg_Out, pack_model()); end
    S_AXI_AWADDR = 32'h17; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h55550002; S_AXI_WVALID = 1'b1;
    tick();
    checks++; if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL b2b_gap: got bv %b awr %b exp 0 1", S_AXI_BVALID, S_AXI_AWREADY); end
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    exp_regs[5] = 32'h55550002;
    checks++; if (S_AXI_BVALID !== 1'b1 || Wr_Pulse !== 1'b1 || Wr_Index !== 4'd5 || Reg_Out !== pack_model()) begin errors++; $display("FAIL b2b_second: got bv %b p %b idx %0d regs %h exp 1 1 5 %h", S_AXI_BVALID, Wr_Pulse, Wr_Index, Reg_Out, pack_model()); end
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    S_AXI_AWADDR = 32'h18; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h66666666; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 32'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1 || Wr_Pulse !== 1'b1) begin errors++; $display("FAIL mid_pending: got bv %b rv %b p %b exp 1 1 1", S_AXI_BVALID, S_AXI_RVALID, Wr_Pulse); end
    rst = 1'b1;
    #1;
    clear_model();
    checks++; if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || S_AXI_RDATA !== 32'h0) begin errors++; $display("FAIL mid_async: got bv %b rv %b d %h exp 0 0 0", S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA); end
    checks++; if (Reg_Out !== pack_model() || Wr_Pulse !== 1'b0 || Wr_Index !== 4'd0) begin errors++; $display("FAIL mid_clear: got regs %h p %b idx %0d exp 0 0 0", Reg_Out, Wr_Pulse, Wr_Index); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin errors++; $display("FAIL mid_ready: got %b exp 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    checks++; if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL mid_no_resp: got bv %b rv %b exp 0 0", S_AXI_BVALID, S_AXI_RVALID); end
  endtask

  initial begin
    rst = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    clear_model();
    #1;
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_out_of_range();
    test_read_backpressure();
    test_concurrent();
    test_wstrb();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
